// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: DIFF = A - B, LSB first, one bit per clock through a
// single full-subtractor cell and a registered borrow, with a start/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int unsigned     CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] d_next;
    logic [CW-1:0]    count;
    logic             bin;
    logic             d;
    logic             bout;

    // Full-subtractor cell on the current LSBs; d_next is the shadow register
    // after this bit lands at the MSB, which is the final result on the last edge.
    always_comb begin
        d               = a_sh[0] ^ b_sh[0] ^ bin;
        bout            = (~a_sh[0] & b_sh[0]) | (bin & ~(a_sh[0] ^ b_sh[0]));
        d_next          = d_sh >> 1;
        d_next[WIDTH-1] = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            d_sh       <= '0;
            count      <= '0;
            bin        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        d_sh  <= '0;
                        bin   <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    d_sh  <= d_next;
                    bin   <= bout;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        diff       <= d_next;
                        borrow_out <= bout;
                        zero       <= (d_next == '0);
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances side by side.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0]  d;
        logic        bo;
        logic        z;
        int unsigned at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, borrow8, zero8;
    logic [7:0]  diff8;

    logic        start1 = 1'b0;
    logic [0:0]  a1 = '0;
    logic [0:0]  b1 = '0;
    logic        busy1, done1, borrow1, zero1;
    logic [0:0]  diff1;

    exp_t q8[$];
    exp_t q1[$];
    exp_t e8, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8), .zero(zero8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1), .zero(zero1)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    // Monitors: pop expected results whenever a DUT presents done
    always @(negedge clk) begin
        if (rst_n && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("spurious_done8", 32'(done8), 32'd0);
            end else begin
                e8 = q8.pop_front();
                chk("diff8", 32'(diff8), 32'(e8.d));
                chk("borrow8", 32'(borrow8), 32'(e8.bo));
                chk("zero8", 32'(zero8), 32'(e8.z));
                chk("latency8", 32'(cyc), 32'(e8.at));
                chk("busy_at_done8", 32'(busy8), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("spurious_done1", 32'(done1), 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("diff1", 32'(diff1), 32'(e1.d));
                chk("borrow1", 32'(borrow1), 32'(e1.bo));
                chk("zero1", 32'(zero1), 32'(e1.z));
                chk("latency1", 32'(cyc), 32'(e1.at));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb);
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        q8.push_back('{ed, eb, (ed == 8'h00), cyc + 1 + 8});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue1(input logic av, input logic bv, input logic ed, input logic eb);
        a1 = av;
        b1 = bv;
        start1 = 1'b1;
        q1.push_back('{{7'd0, ed}, eb, (ed == 1'b0), cyc + 1 + 1});
        @(negedge clk);
        start1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc;
        int dc;

        // reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_diff", 32'(diff8), 32'd0);
        chk("rst_borrow", 32'(borrow8), 32'd0);
        chk("rst_zero", 32'(zero8), 32'd1);
        rst_n = 1'b1;
        idle(2);

        // basic, with busy duration
        issue8(8'h2D, 8'h0F, 8'h1E, 1'b0);
        bc = 0;
        repeat (10) begin
            if (busy8) bc++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(bc), 32'd8);

        // underflow and equal operands
        issue8(8'h00, 8'h01, 8'hFF, 1'b1);
        idle(10);
        issue8(8'h10, 8'h80, 8'h90, 1'b1);
        idle(10);
        issue8(8'hA5, 8'hA5, 8'h00, 1'b0);
        idle(10);

        // operand changes and start pulses during SHIFT are ignored
        issue8(8'hC3, 8'h42, 8'h81, 1'b0);
        idle(2);
        a8 = 8'h00;
        b8 = 8'h01;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'h77;
        b8 = 8'h99;
        idle(8);

        // start held 20 cycles with changing operands: accepts at i=0, 9, 18
        q8.push_back('{8'h40, 1'b0, 1'b0, cyc + 1 + 8});
        q8.push_back('{8'h37, 1'b0, 1'b0, cyc + 1 + 8 + 9});
        q8.push_back('{8'h2E, 1'b0, 1'b0, cyc + 1 + 8 + 18});
        start8 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a8 = 8'h50 + 8'(i);
            b8 = 8'h10 + 8'(2 * i);
            @(negedge clk);
        end
        start8 = 1'b0;
        idle(10);

        // WIDTH=1: all four operand combinations
        issue1(1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        issue1(1'b0, 1'b1, 1'b1, 1'b1);
        idle(2);
        issue1(1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        issue1(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);

        // reset during shift 4 of 0x80-0x01: no result expected
        a8 = 8'h80;
        b8 = 8'h01;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_diff", 32'(diff8), 32'd0);
        chk("mid_rst_zero", 32'(zero8), 32'd1);
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_borrow", 32'(borrow8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 || busy8) dc++;
        end
        chk("no_done_after_rst", 32'(dc), 32'd0);

        // recovery after reset
        issue8(8'hFF, 8'h01, 8'hFE, 1'b0);
        idle(10);

        chk("pending8", 32'(q8.size()), 32'd0);
        chk("pending1", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
